// File: rtl/fft_unload.sv
// fft_unload: captures a 32-point FFT result (8 beats x 4 lanes) and streams it out over valid/ready/last.
// Build option FFT_UNLOAD_BITREV_EN: stream buf[bitrev(n)] instead of buf[n] (natural order from a bit-reversed core).
module fft_unload #(
    parameter int WORDSIZE   = 16,
    parameter int NUMSAMPLES = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fft_done,
    output logic                output_data,
    input  logic                in_valid,
    input  logic [WORDSIZE-1:0] fft_out0,
    input  logic [WORDSIZE-1:0] fft_out1,
    input  logic [WORDSIZE-1:0] fft_out2,
    input  logic [WORDSIZE-1:0] fft_out3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] out_data,
    output logic                out_last,
    output logic                busy,
    output logic                err
);

    localparam int AW = $clog2(NUMSAMPLES);
    localparam int BW = AW - 2;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, WAIT_CLR} state_t;

    state_t              state;
    logic [BW-1:0]       beat_cnt;
    logic [AW-1:0]       rd_idx;
    logic [AW-1:0]       next_idx;
    logic [WORDSIZE-1:0] mem [NUMSAMPLES];

    function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] idx);
`ifdef FFT_UNLOAD_BITREV_EN
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < AW; i++) r[i] = idx[AW-1-i];
        return r;
`else
        return idx;
`endif
    endfunction

    assign next_idx = rd_idx + 1'b1;
    assign busy     = (state != IDLE);

    // Sample buffer carries no reset; its contents are only meaningful after a full collect.
    always_ff @(posedge clk) begin
        if (state == COLLECT && in_valid) begin
            mem[{beat_cnt, 2'd0}] <= fft_out0;
            mem[{beat_cnt, 2'd1}] <= fft_out1;
            mem[{beat_cnt, 2'd2}] <= fft_out2;
            mem[{beat_cnt, 2'd3}] <= fft_out3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            rd_idx      <= '0;
            output_data <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            err         <= 1'b0;
        end else begin
            if (in_valid && state != COLLECT) err <= 1'b1;
            case (state)
                IDLE: begin
                    if (fft_done) begin
                        state       <= COLLECT;
                        output_data <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // Word 0 comes from beat 0, so it can be presented on the same edge as the last beat.
                        if (beat_cnt == '1) begin
                            state       <= DRAIN;
                            output_data <= 1'b0;
                            out_valid   <= 1'b1;
                            out_last    <= 1'b0;
                            out_data    <= mem[rd_addr(rd_idx)];
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        rd_idx <= next_idx;
                        if (out_last) begin
                            state     <= WAIT_CLR;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_data <= mem[rd_addr(next_idx)];
                            out_last <= (next_idx == AW'(NUMSAMPLES - 1));
                        end
                    end
                end
                WAIT_CLR: begin
                    if (!fft_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_unload.sv
// tb_fft_unload: scoreboard bench for fft_unload; expected words are queued when a frame is driven.
// Honors FFT_UNLOAD_BITREV_EN the same way as the design build.
module tb_fft_unload;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fft_done = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] fft_out0 = '0, fft_out1 = '0, fft_out2 = '0, fft_out3 = '0;
    logic         output_data, out_valid, out_last, busy, err;
    logic [W-1:0] out_data;

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    bit           stall_pend = 0;
    logic [W-1:0] held_data;
    logic         held_last;

    fft_unload #(.WORDSIZE(W), .NUMSAMPLES(32)) dut (
        .clk(clk), .rst_n(rst_n), .fft_done(fft_done), .output_data(output_data),
        .in_valid(in_valid), .fft_out0(fft_out0), .fft_out1(fft_out1),
        .fft_out2(fft_out2), .fft_out3(fft_out3), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Stream position n maps to buffer index n, or its 5-bit mirror image in bit-reverse builds.
    function automatic int exp_idx(input int n);
        logic [4:0] v, r;
        v = 5'(n);
`ifdef FFT_UNLOAD_BITREV_EN
        r = {v[0], v[1], v[2], v[3], v[4]};
`else
        r = v;
`endif
        return int'(r);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 0;
        end else begin
            if (stall_pend) begin
                check("stall_data", out_data, held_data);
                check("stall_last", out_last, held_last);
            end
            stall_pend = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word", out_data, e.data);
                    check("last", out_last, e.last);
                end
            end else if (out_valid) begin
                stall_pend = 1;
                held_data  = out_data;
                held_last  = out_last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic collect(input int base, input int nbeats);
        fft_done = 1'b1;
        tick();
        check("od_rise", output_data, 1);
        check("busy_collect", busy, 1);
        for (int b = 0; b < nbeats; b++) begin
            check("od_window", output_data, 1);
            in_valid = 1'b1;
            fft_out0 = W'(base + 4*b + 0);
            fft_out1 = W'(base + 4*b + 1);
            fft_out2 = W'(base + 4*b + 2);
            fft_out3 = W'(base + 4*b + 3);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int base, input bit toggle, input bit err_pulse);
        int cyc;
        for (int n = 0; n < 32; n++) sb.push_back('{data: W'(base + exp_idx(n)), last: (n == 31)});
        out_ready = toggle ? 1'b0 : 1'b1;
        collect(base, 8);
        check("od_fall", output_data, 0);
        check("ov_rise", out_valid, 1);
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            if (err_pulse && cyc == 5) begin
                in_valid = 1'b1;
                fft_out0 = 16'hFFFF; fft_out1 = 16'hFFFF;
                fft_out2 = 16'hFFFF; fft_out3 = 16'hFFFF;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            cyc++;
            if (toggle) out_ready = ~out_ready;
        end
        in_valid = 1'b0;
        check("drain_timeout", 32'(sb.size()), 0);
        check("drain_cycles", cyc, toggle ? 64 : 32);
        check("ov_fall", out_valid, 0);
        check("last_fall", out_last, 0);
        // fft_done still high: must park in WAIT_CLR without re-requesting.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wait_clr_od", output_data, 0);
            check("wait_clr_busy", busy, 1);
        end
        fft_done = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("reset_outs", {output_data, out_valid, out_last, busy, err, out_data}, 0);
            tick();
        end

        run_frame(0, 1'b0, 1'b0);
        check("err_clean", err, 0);

        run_frame('h100, 1'b1, 1'b0);
        check("err_clean2", err, 0);

        run_frame('h180, 1'b0, 1'b1);
        check("err_set", err, 1);
        repeat (3) tick();
        check("err_sticky", err, 1);

        collect('h300, 4);
        check("busy_partial", busy, 1);
        rst_n = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_od", output_data, 0);
        check("rst_ov", out_valid, 0);
        check("rst_err", err, 0);
        fft_done = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_frame('h200, 1'b0, 1'b0);
        check("err_after_rst", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
